// File: rtl/id_ex_stage_pkg.sv
// id_ex_stage_pkg: writeback source encodings shared with the register-file writeback mux and the MEM stage
package id_ex_stage_pkg;
  localparam logic [1:0] WB_PC4  = 2'b00;
  localparam logic [1:0] WB_ALU  = 2'b01;
  localparam logic [1:0] WB_DRAM = 2'b10;
  localparam logic [1:0] WB_SEXT = 2'b11;
endpackage

// File: rtl/id_ex_stage_fwd_mux.sv
// fwd_mux: priority operand selector x0 > EX > MEM > WB > register file
module fwd_mux (
  input  logic [4:0]  rs,
  input  logic [31:0] rf_data,
  input  logic        ex_fwd,
  input  logic [4:0]  ex_rd,
  input  logic [31:0] ex_data,
  input  logic        mem_we,
  input  logic [4:0]  mem_rd,
  input  logic [31:0] mem_data,
  input  logic        wb_we,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data,
  output logic [31:0] data
);
  assign data = (rs == 5'd0)               ? 32'd0 :
                (ex_fwd && ex_rd == rs)    ? ex_data :
                (mem_we && mem_rd == rs)   ? mem_data :
                (wb_we && wb_rd == rs)     ? wb_data : rf_data;
endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: operand forwarding, load-use stall, flush and the ID/EX pipeline register
module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int CTRL_W = 16,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [31:0]       id_pc,
  input  logic [31:0]       id_ext,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic [4:0]        id_rs1,
  input  logic [4:0]        id_rs2,
  input  logic [1:0]        id_use,
  input  logic [4:0]        id_rd,
  input  logic              id_we,
  input  logic [1:0]        id_wb_sel,
  input  logic [31:0]       id_rd1,
  input  logic [31:0]       id_rd2,
  input  logic [31:0]       ex_alu_result,
  input  logic [4:0]        mem_rd,
  input  logic              mem_we,
  input  logic [31:0]       mem_fwd_data,
  input  logic [4:0]        wb_rd,
  input  logic              wb_we,
  input  logic [31:0]       wb_data,
  input  logic              ex_flush,
  output logic              stall,
  output logic              ex_valid,
  output logic [31:0]       ex_pc,
  output logic [31:0]       ex_pc4,
  output logic [31:0]       ex_ext,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic [4:0]        ex_rd,
  output logic              ex_we,
  output logic [1:0]        ex_wb_sel,
  output logic [31:0]       ex_op1,
  output logic [31:0]       ex_op2,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);
  logic        ex_fwd;
  logic [31:0] op1, op2;
  // Only ALU producers forward from EX; loads must wait a cycle and arrive via MEM
  assign ex_fwd = ex_valid && ex_we && ex_wb_sel == WB_ALU;
  assign stall = ex_valid && ex_we && ex_rd != 5'd0 && ex_wb_sel == WB_DRAM && id_valid &&
                 ((id_use[0] && id_rs1 == ex_rd) || (id_use[1] && id_rs2 == ex_rd));
  fwd_mux u_fwd1 (
    .rs(id_rs1), .rf_data(id_rd1), .ex_fwd(ex_fwd), .ex_rd(ex_rd), .ex_data(ex_alu_result),
    .mem_we(mem_we), .mem_rd(mem_rd), .mem_data(mem_fwd_data),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data), .data(op1)
  );
  fwd_mux u_fwd2 (
    .rs(id_rs2), .rf_data(id_rd2), .ex_fwd(ex_fwd), .ex_rd(ex_rd), .ex_data(ex_alu_result),
    .mem_we(mem_we), .mem_rd(mem_rd), .mem_data(mem_fwd_data),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data), .data(op2)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid  <= 1'b0;
      ex_pc     <= '0;
      ex_pc4    <= '0;
      ex_ext    <= '0;
      ex_ctrl   <= '0;
      ex_rd     <= '0;
      ex_we     <= 1'b0;
      ex_wb_sel <= '0;
      ex_op1    <= '0;
      ex_op2    <= '0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (ex_flush || stall) begin
        ex_valid  <= 1'b0;
        ex_pc     <= '0;
        ex_pc4    <= '0;
        ex_ext    <= '0;
        ex_ctrl   <= '0;
        ex_rd     <= '0;
        ex_we     <= 1'b0;
        ex_wb_sel <= WB_PC4;
        ex_op1    <= '0;
        ex_op2    <= '0;
      end else begin
        ex_valid  <= id_valid;
        ex_pc     <= id_pc;
        ex_pc4    <= id_pc + 32'd4;
        ex_ext    <= id_ext;
        ex_ctrl   <= id_ctrl;
        ex_rd     <= id_rd;
        ex_we     <= id_we && id_valid;
        ex_wb_sel <= id_wb_sel;
        ex_op1    <= op1;
        ex_op2    <= op2;
      end
      stall_cnt <= stall_cnt + CNT_W'(stall && !ex_flush);
      flush_cnt <= flush_cnt + CNT_W'(ex_flush && id_valid);
    end
  end
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed checks of forwarding, load-use stall, flush, x0 handling and reset
module tb_id_ex_stage;
  import id_ex_stage_pkg::*;
  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid;
  logic [31:0] id_pc, id_ext;
  logic [15:0] id_ctrl;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic [1:0]  id_use, id_wb_sel;
  logic        id_we;
  logic [31:0] id_rd1, id_rd2, ex_alu_result;
  logic [4:0]  mem_rd, wb_rd;
  logic        mem_we, wb_we, ex_flush;
  logic [31:0] mem_fwd_data, wb_data;
  logic        stall, ex_valid, ex_we;
  logic [31:0] ex_pc, ex_pc4, ex_ext, ex_op1, ex_op2;
  logic [15:0] ex_ctrl;
  logic [4:0]  ex_rd;
  logic [1:0]  ex_wb_sel;
  logic [31:0] stall_cnt, flush_cnt;
  int errors = 0;
  int checks = 0;

  id_ex_stage #(.CTRL_W(16), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_pc(id_pc), .id_ext(id_ext), .id_ctrl(id_ctrl),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use(id_use), .id_rd(id_rd), .id_we(id_we),
    .id_wb_sel(id_wb_sel), .id_rd1(id_rd1), .id_rd2(id_rd2), .ex_alu_result(ex_alu_result),
    .mem_rd(mem_rd), .mem_we(mem_we), .mem_fwd_data(mem_fwd_data), .wb_rd(wb_rd), .wb_we(wb_we),
    .wb_data(wb_data), .ex_flush(ex_flush), .stall(stall), .ex_valid(ex_valid), .ex_pc(ex_pc),
    .ex_pc4(ex_pc4), .ex_ext(ex_ext), .ex_ctrl(ex_ctrl), .ex_rd(ex_rd), .ex_we(ex_we),
    .ex_wb_sel(ex_wb_sel), .ex_op1(ex_op1), .ex_op2(ex_op2), .stall_cnt(stall_cnt),
    .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_valid = 0; id_pc = 0; id_ext = 0; id_ctrl = 0; id_rs1 = 0; id_rs2 = 0; id_use = 0;
    id_rd = 0; id_we = 0; id_wb_sel = WB_PC4; id_rd1 = 0; id_rd2 = 0; ex_alu_result = 0;
    mem_rd = 0; mem_we = 0; mem_fwd_data = 0; wb_rd = 0; wb_we = 0; wb_data = 0; ex_flush = 0;
  endtask

  task automatic issue(input logic [4:0] rd, input logic [1:0] sel);
    id_valid = 1; id_rd = rd; id_we = 1; id_wb_sel = sel; id_use = 0; id_rs1 = 0; id_rs2 = 0;
  endtask

  initial begin
    idle();
    rst = 1;
    step(); step();
    rst = 0;
    chk("rst_valid", 32'(ex_valid), 0);
    chk("rst_pc", ex_pc, 0);
    chk("rst_wb_sel", 32'(ex_wb_sel), 0);
    chk("rst_stall", 32'(stall), 0);
    // plain issue, also writes x3 through the ALU
    id_pc = 32'h100; id_rd1 = 5; id_rs1 = 1; id_use = 2'b01; id_ctrl = 16'hBEEF;
    id_ext = 32'hFFFF_FFF0; id_valid = 1; id_rd = 3; id_we = 1; id_wb_sel = WB_ALU;
    step();
    chk("basic_pc", ex_pc, 32'h100);
    chk("basic_pc4", ex_pc4, 32'h104);
    chk("basic_op1", ex_op1, 5);
    chk("basic_valid", 32'(ex_valid), 1);
    chk("basic_ctrl", 32'(ex_ctrl), 32'hBEEF);
    chk("basic_ext", ex_ext, 32'hFFFF_FFF0);
    chk("basic_rd_we", {ex_rd, ex_we}, {5'd3, 1'b1});
    chk("basic_cnts", stall_cnt | flush_cnt, 0);
    // forwarding priority EX > MEM > WB > RF
    idle();
    id_valid = 1; id_rs1 = 3; id_rs2 = 3; id_use = 2'b11; id_rd1 = 32'h11; id_rd2 = 32'h22;
    ex_alu_result = 32'hAA; mem_we = 1; mem_rd = 3; mem_fwd_data = 32'hBB;
    wb_we = 1; wb_rd = 3; wb_data = 32'hCC;
    step();
    chk("fwd_ex_op1", ex_op1, 32'hAA);
    chk("fwd_ex_op2", ex_op2, 32'hAA);
    step();
    chk("fwd_mem", ex_op1, 32'hBB);
    mem_we = 0;
    step();
    chk("fwd_wb", ex_op1, 32'hCC);
    wb_we = 0;
    step();
    chk("fwd_rf", ex_op1, 32'h11);
    // PC4 producer in EX neither forwards nor stalls
    idle(); issue(3, WB_PC4);
    step();
    idle(); id_valid = 1; id_rs1 = 3; id_use = 2'b01; id_rd1 = 32'h77; ex_alu_result = 32'hAA;
    #1;
    chk("pc4_nostall", 32'(stall), 0);
    step();
    chk("pc4_nofwd", ex_op1, 32'h77);
    // load-use on rs2 costs one bubble, then forwards from MEM
    idle(); issue(5, WB_DRAM);
    step();
    idle(); id_valid = 1; id_rs2 = 5; id_use = 2'b10; id_rd2 = 32'h99; id_rd = 6; id_we = 1;
    id_wb_sel = WB_ALU;
    #1;
    chk("lu_stall", 32'(stall), 1);
    step();
    chk("lu_bubble_valid", 32'(ex_valid), 0);
    chk("lu_bubble_fields", {ex_we, ex_rd, ex_wb_sel}, {1'b0, 5'd0, WB_PC4});
    chk("lu_stall_cnt", stall_cnt, 1);
    chk("lu_stall_clear", 32'(stall), 0);
    mem_we = 1; mem_rd = 5; mem_fwd_data = 32'h1234;
    step();
    chk("lu_op2", ex_op2, 32'h1234);
    chk("lu_valid", 32'(ex_valid), 1);
    chk("lu_stall_cnt2", stall_cnt, 1);
    // unused source bit masks the hazard
    idle(); issue(5, WB_DRAM);
    step();
    idle(); id_valid = 1; id_rs1 = 7; id_rs2 = 5; id_use = 2'b01;
    #1;
    chk("lu_masked", 32'(stall), 0);
    step();
    // flush beats stall
    idle(); issue(5, WB_DRAM);
    step();
    idle(); id_valid = 1; id_rs2 = 5; id_use = 2'b10; id_rd = 6; id_we = 1; ex_flush = 1;
    #1;
    chk("fl_stall_seen", 32'(stall), 1);
    step();
    chk("fl_valid", 32'(ex_valid), 0);
    chk("fl_stall_cnt", stall_cnt, 1);
    chk("fl_flush_cnt", flush_cnt, 1);
    // x0 never forwards and never stalls
    idle(); id_valid = 1; id_rs1 = 0; id_use = 2'b01; id_rd1 = 32'h77;
    mem_we = 1; mem_rd = 0; mem_fwd_data = 32'hFFFF;
    step();
    chk("x0_op1", ex_op1, 0);
    idle(); issue(0, WB_DRAM);
    step();
    idle(); id_valid = 1; id_rs1 = 0; id_use = 2'b01;
    #1;
    chk("x0_nostall", 32'(stall), 0);
    // invalid ID slot loads fields but drops the write enable
    idle(); id_rd = 9; id_we = 1; id_wb_sel = WB_ALU; id_pc = 32'hFFFF_FFFC;
    step();
    chk("inv_we", {ex_valid, ex_we, ex_rd}, {1'b0, 1'b0, 5'd9});
    chk("inv_pc4_wrap", ex_pc4, 0);
    // mid-stream reset
    idle(); issue(5, WB_DRAM); id_pc = 32'h200;
    step();
    chk("pre_rst_valid", 32'(ex_valid), 1);
    idle(); id_valid = 1; id_rs1 = 5; id_use = 2'b01; rst = 1;
    step();
    rst = 0;
    chk("rst2_fields", {ex_valid, ex_we, ex_rd, ex_wb_sel, ex_ctrl}, 0);
    chk("rst2_data", ex_pc | ex_pc4 | ex_op1 | ex_op2 | ex_ext, 0);
    chk("rst2_cnts", stall_cnt | flush_cnt, 0);
    chk("rst2_stall", 32'(stall), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
